// File: rtl/lsm.sv
// Load/store stage: passes ALU results to write-back and runs single-beat
// request/acknowledge transactions on the data bus for loads and stores.
module lsm #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        input_ready_o,
   input  logic        input_valid_i,
   input  logic        result_write_i,
   input  logic [4:0]  result_addr_i,
   input  logic [31:0] result_i,
   input  logic        ls_enable_i,
   input  logic        ls_write_i,
   input  logic [1:0]  ls_size_i,
   input  logic        ls_unsigned_i,
   input  logic [31:0] ls_wdata_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_sel_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        reg_write_o,
   output logic [4:0]  reg_addr_o,
   output logic [31:0] reg_data_o,
   output logic        misaligned_o,
   output logic        bus_error_o
);

   typedef enum logic {
      S_IDLE,
      S_REQ
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;

   // Last counter value before the request is abandoned.
   localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_cnt;

   // Transaction context captured at accept time.
   logic [1:0]  r_offset;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [4:0]  r_rd;
   logic        r_we;
   logic [31:0] r_mem_addr;
   logic [3:0]  r_mem_sel;
   logic [31:0] r_mem_wdata;

   logic        r_reg_write;
   logic [4:0]  r_reg_addr;
   logic [31:0] r_reg_data;
   logic        r_misaligned;
   logic        r_bus_error;

   logic        w_accept;
   logic        w_misaligned;
   logic        w_start;
   logic        w_ack_done;
   logic        w_timeout;
   logic [1:0]  w_offset;
   logic [3:0]  w_sel;
   logic [31:0] w_wdata;
   logic [31:0] w_shifted;
   logic [31:0] w_load_data;

   assign input_ready_o = (r_state == S_IDLE);
   assign mem_req_o     = (r_state == S_REQ);
   assign mem_we_o      = r_we;
   assign mem_addr_o    = r_mem_addr;
   assign mem_sel_o     = r_mem_sel;
   assign mem_wdata_o   = r_mem_wdata;
   assign reg_write_o   = r_reg_write;
   assign reg_addr_o    = r_reg_addr;
   assign reg_data_o    = r_reg_data;
   assign misaligned_o  = r_misaligned;
   assign bus_error_o   = r_bus_error;

   assign w_accept = input_valid_i && input_ready_o;
   assign w_offset = result_i[1:0];
   assign w_start  = w_accept && ls_enable_i && !w_misaligned;

   // Alignment check, lane enables and lane-shifted store data for the incoming access.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      w_misaligned = 1'b0;
      w_sel        = 4'b1111;
      w_wdata      = ls_wdata_i << {w_offset, 3'b000};
      case (ls_size_i)
         SZ_BYTE: w_sel = 4'b0001 << w_offset;
         SZ_HALF: begin
            w_sel        = 4'b0011 << w_offset;
            w_misaligned = ls_enable_i && w_offset[0];
         end
         default: w_misaligned = ls_enable_i && (w_offset != 2'b00);
      endcase
   end

   // Load data: shift the addressed lane down, then sign- or zero-extend by size.
   always_comb begin
      w_shifted   = mem_rdata_i >> {r_offset, 3'b000};
      w_load_data = w_shifted;
      case (r_size)
         SZ_BYTE: w_load_data = r_unsigned ? {24'd0, w_shifted[7:0]}
                                           : {{24{w_shifted[7]}}, w_shifted[7:0]};
         SZ_HALF: w_load_data = r_unsigned ? {16'd0, w_shifted[15:0]}
                                           : {{16{w_shifted[15]}}, w_shifted[15:0]};
         default: w_load_data = w_shifted;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic; an ack in the last allowed cycle still completes normally.
   always_comb begin
      w_state_nxt = r_state;
      w_ack_done  = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: if (w_start) w_state_nxt = S_REQ;
         S_REQ: begin
            if (mem_ack_i) begin
               w_state_nxt = S_IDLE;
               w_ack_done  = 1'b1;
            end else if (r_cnt == LP_CNT_LAST) begin
               w_state_nxt = S_IDLE;
               w_timeout   = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Timeout counter: counts un-acked request cycles, cleared whenever the request ends.
   always_ff @(posedge clk_i) begin
      if (rst_i)                                              r_cnt <= 8'd0;
      else if (r_state == S_REQ && w_state_nxt == S_REQ)      r_cnt <= r_cnt + 8'd1;
      else                                                    r_cnt <= 8'd0;
   end

   // Capture transaction context and bus outputs when an aligned access is accepted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_offset    <= 2'd0;
         r_size      <= 2'd0;
         r_unsigned  <= 1'b0;
         r_rd        <= 5'd0;
         r_we        <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_sel   <= 4'd0;
         r_mem_wdata <= 32'd0;
      end else if (w_start) begin
         r_offset    <= w_offset;
         r_size      <= ls_size_i;
         r_unsigned  <= ls_unsigned_i;
         r_rd        <= result_addr_i;
         r_we        <= ls_write_i;
         r_mem_addr  <= {result_i[31:2], 2'b00};
         r_mem_sel   <= w_sel;
         r_mem_wdata <= w_wdata;
      end
   end

   // Write-back and status pulses; address/data hold their last written value.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_reg_write  <= 1'b0;
         r_reg_addr   <= 5'd0;
         r_reg_data   <= 32'd0;
         r_misaligned <= 1'b0;
         r_bus_error  <= 1'b0;
      end else begin
         r_reg_write  <= 1'b0;
         r_misaligned <= 1'b0;
         r_bus_error  <= w_timeout;
         if (w_accept && !ls_enable_i) begin
            r_reg_write <= result_write_i && (result_addr_i != 5'd0);
            r_reg_addr  <= result_addr_i;
            r_reg_data  <= result_i;
         end else if (w_accept && w_misaligned) begin
            r_misaligned <= 1'b1;
         end
         if (w_ack_done && !r_we) begin
            r_reg_write <= (r_rd != 5'd0);
            r_reg_addr  <= r_rd;
            r_reg_data  <= w_load_data;
         end
      end
   end

endmodule

// File: tb/tb_lsm.sv
// Directed testbench for lsm with TIMEOUT_CYCLES=4.
module tb_lsm;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        input_ready_o;
   logic        input_valid_i;
   logic        result_write_i;
   logic [4:0]  result_addr_i;
   logic [31:0] result_i;
   logic        ls_enable_i;
   logic        ls_write_i;
   logic [1:0]  ls_size_i;
   logic        ls_unsigned_i;
   logic [31:0] ls_wdata_i;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_sel_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        reg_write_o;
   logic [4:0]  reg_addr_o;
   logic [31:0] reg_data_o;
   logic        misaligned_o;
   logic        bus_error_o;

   int n_tests = 0;
   int n_fail  = 0;

   lsm #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .input_ready_o(input_ready_o),
      .input_valid_i(input_valid_i), .result_write_i(result_write_i),
      .result_addr_i(result_addr_i), .result_i(result_i),
      .ls_enable_i(ls_enable_i), .ls_write_i(ls_write_i), .ls_size_i(ls_size_i),
      .ls_unsigned_i(ls_unsigned_i), .ls_wdata_i(ls_wdata_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_sel_o(mem_sel_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i), .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o),
      .reg_data_o(reg_data_o), .misaligned_o(misaligned_o), .bus_error_o(bus_error_o)
   );

   always #5 clk_i = ~clk_i;

   // Compare one observed value against its expected value.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      input_valid_i  = 1'b0;
      result_write_i = 1'b0;
      result_addr_i  = 5'd0;
      result_i       = 32'd0;
      ls_enable_i    = 1'b0;
      ls_write_i     = 1'b0;
      ls_size_i      = 2'd0;
      ls_unsigned_i  = 1'b0;
      ls_wdata_i     = 32'd0;
      mem_ack_i      = 1'b0;
      mem_rdata_i    = 32'd0;
   endtask

   task automatic drive_alu(input logic wr, input logic [4:0] rd, input logic [31:0] val);
      input_valid_i  = 1'b1;
      ls_enable_i    = 1'b0;
      result_write_i = wr;
      result_addr_i  = rd;
      result_i       = val;
   endtask

   task automatic drive_mem(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [4:0] rd, input logic [31:0] addr,
                            input logic [31:0] wdata);
      input_valid_i  = 1'b1;
      ls_enable_i    = 1'b1;
      result_write_i = !we;
      ls_write_i     = we;
      ls_size_i      = sz;
      ls_unsigned_i  = uns;
      result_addr_i  = rd;
      result_i       = addr;
      ls_wdata_i     = wdata;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_req;
      idle_inputs();
      rst_i = 1'b1;
      step();
      step();
      rst_i = 1'b0;
      step();
      check("rst_ready",   input_ready_o, 1);
      check("rst_req",     mem_req_o, 0);
      check("rst_regw",    reg_write_o, 0);
      check("rst_regdata", reg_data_o, 0);
      check("rst_addr",    mem_addr_o, 0);
      check("rst_mis",     misaligned_o, 0);
      check("rst_berr",    bus_error_o, 0);

      // ALU pass-through, rd=0 suppression, back-to-back throughput.
      drive_alu(1, 5'd5, 32'h1234);
      step();
      check("alu_regw", reg_write_o, 1);
      check("alu_addr", reg_addr_o, 5);
      check("alu_data", reg_data_o, 32'h1234);
      drive_alu(1, 5'd0, 32'h55);
      step();
      check("alu_rd0_regw", reg_write_o, 0);
      drive_alu(1, 5'd7, 32'hAAAA_0001);
      step();
      check("b2b_a_data", reg_data_o, 32'hAAAA_0001);
      check("b2b_ready",  input_ready_o, 1);
      drive_alu(1, 5'd8, 32'hBBBB_0002);
      step();
      check("b2b_b_regw", reg_write_o, 1);
      check("b2b_b_addr", reg_addr_o, 8);
      check("b2b_b_data", reg_data_o, 32'hBBBB_0002);
      idle_inputs();
      step();
      check("alu_pulse", reg_write_o, 0);

      // Signed byte load at 0x1003, ack in second REQ cycle.
      drive_mem(0, 2'd0, 0, 5'd3, 32'h1003, 32'd0);
      step();
      idle_inputs();
      check("lb_req",   mem_req_o, 1);
      check("lb_we",    mem_we_o, 0);
      check("lb_addr",  mem_addr_o, 32'h1000);
      check("lb_sel",   mem_sel_o, 4'b1000);
      check("lb_ready", input_ready_o, 0);
      drive_alu(1, 5'd9, 32'hDEAD);   // must be ignored while busy
      step();
      idle_inputs();
      check("lb_busy_regw",  reg_write_o, 0);
      check("lb_busy_ready", input_ready_o, 0);
      check("lb_busy_req",   mem_req_o, 1);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h80FF_FFFF;
      step();
      idle_inputs();
      check("lb_done_req",  mem_req_o, 0);
      check("lb_regw",      reg_write_o, 1);
      check("lb_regaddr",   reg_addr_o, 3);
      check("lb_data",      reg_data_o, 32'hFFFF_FF80);
      check("lb_done_ready", input_ready_o, 1);

      // Unsigned half load at 0x1002, ack in first REQ cycle.
      drive_mem(0, 2'd1, 1, 5'd4, 32'h1002, 32'd0);
      step();
      idle_inputs();
      check("lhu_sel", mem_sel_o, 4'b1100);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h8001_1234;
      step();
      idle_inputs();
      check("lhu_regw", reg_write_o, 1);
      check("lhu_data", reg_data_o, 32'h0000_8001);

      // Half store at 0x2002.
      drive_mem(1, 2'd1, 0, 5'd6, 32'h2002, 32'h0000_ABCD);
      step();
      idle_inputs();
      check("sh_we",    mem_we_o, 1);
      check("sh_addr",  mem_addr_o, 32'h2000);
      check("sh_sel",   mem_sel_o, 4'b1100);
      check("sh_wdata", mem_wdata_o, 32'hABCD_0000);
      mem_ack_i = 1'b1;
      step();
      idle_inputs();
      check("sh_regw",  reg_write_o, 0);
      check("sh_ready", input_ready_o, 1);
      check("sh_req",   mem_req_o, 0);

      // Byte store at offset 1.
      drive_mem(1, 2'd0, 0, 5'd0, 32'h2001, 32'h1234_5678);
      step();
      idle_inputs();
      check("sb_sel",   mem_sel_o, 4'b0010);
      check("sb_wdata", mem_wdata_o, 32'h3456_7800);
      mem_ack_i = 1'b1;
      step();
      idle_inputs();
      check("sb_regw", reg_write_o, 0);

      // Misaligned accesses.
      drive_mem(0, 2'd2, 0, 5'd2, 32'h3001, 32'd0);
      step();
      idle_inputs();
      check("mis_w_pulse", misaligned_o, 1);
      check("mis_w_req",   mem_req_o, 0);
      check("mis_w_regw",  reg_write_o, 0);
      check("mis_w_ready", input_ready_o, 1);
      step();
      check("mis_w_clear", misaligned_o, 0);
      drive_mem(0, 2'd1, 0, 5'd2, 32'h3003, 32'd0);
      step();
      idle_inputs();
      check("mis_h_pulse", misaligned_o, 1);
      drive_mem(1, 2'd3, 0, 5'd0, 32'h3002, 32'd0);
      step();
      idle_inputs();
      check("mis_sz3_pulse", misaligned_o, 1);
      check("mis_sz3_req",   mem_req_o, 0);

      // Timeout: request stays up for 4 cycles, then bus error.
      drive_mem(0, 2'd2, 0, 5'd1, 32'h4000, 32'd0);
      step();
      idle_inputs();
      n_req = 0;
      while (mem_req_o && n_req < 10) begin
         n_req++;
         step();
      end
      check("to_req_cycles", n_req, 4);
      check("to_berr",  bus_error_o, 1);
      check("to_regw",  reg_write_o, 0);
      check("to_ready", input_ready_o, 1);
      step();
      check("to_berr_clear", bus_error_o, 0);

      // Ack in the 4th REQ cycle completes normally.
      drive_mem(0, 2'd2, 0, 5'd10, 32'h4004, 32'd0);
      step();
      idle_inputs();
      step();
      step();
      step();
      check("late_req", mem_req_o, 1);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'hCAFE_F00D;
      step();
      idle_inputs();
      check("late_berr", bus_error_o, 0);
      check("late_regw", reg_write_o, 1);
      check("late_addr", reg_addr_o, 10);
      check("late_data", reg_data_o, 32'hCAFE_F00D);
      check("late_req_off", mem_req_o, 0);

      // Reset in the middle of a request, then a stray ack.
      drive_mem(0, 2'd2, 0, 5'd11, 32'h5000, 32'd0);
      step();
      idle_inputs();
      check("rr_req", mem_req_o, 1);
      rst_i = 1'b1;
      step();
      check("rr_req_off", mem_req_o, 0);
      check("rr_regw",    reg_write_o, 0);
      rst_i = 1'b0;
      step();
      check("rr_ready", input_ready_o, 1);
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'h0000_FFFF;
      step();
      idle_inputs();
      check("rr_stray_regw", reg_write_o, 0);
      check("rr_stray_req",  mem_req_o, 0);
      check("rr_stray_data", reg_data_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lsm.md
Name: lsm

Overview:
- Load/store stage directly downstream of the execute stage.
- Consumes the execute result, write-back controls and load/store controls.
- Non-memory instructions pass through to register write-back with 1-cycle latency.
- Loads and stores run a single-beat request/acknowledge transaction on the data bus. Load data is aligned, then sign- or zero-extended before write-back.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles mem_req_o stays high without mem_ack_i before the transaction is aborted; range 1..255 (8-bit counter).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- input_ready_o  out  1  stage can accept an instruction.
- input_valid_i  in  1  upstream instruction valid.
- result_write_i  in  1  instruction writes a register.
- result_addr_i  in  5  destination register.
- result_i  in  32  execute result; byte address for load/store.
- ls_enable_i  in  1  instruction is a load or store.
- ls_write_i  in  1  1 = store, 0 = load.
- ls_size_i  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- ls_unsigned_i  in  1  zero-extend load data.
- ls_wdata_i  in  32  store data, low-aligned.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  bus write enable.
- mem_addr_o  out  32  word-aligned address: {addr[31:2],2'b00}.
- mem_sel_o  out  4  byte lane enables.
- mem_wdata_o  out  32  lane-shifted store data.
- mem_ack_i  in  1  single-cycle acknowledge.
- mem_rdata_i  in  32  read data; valid with mem_ack_i.
- reg_write_o  out  1  write-back strobe (1-cycle pulse).
- reg_addr_o  out  5  write-back register.
- reg_data_o  out  32  write-back data.
- misaligned_o  out  1  1-cycle pulse: misaligned access dropped.
- bus_error_o  out  1  1-cycle pulse: bus timeout abort.

Behaviour:
- Reset: state=IDLE. All outputs are 0, except input_ready_o, which is 1 from the first cycle after reset. Timeout counter is 0.
- input_ready_o = (state==IDLE), combinational. An instruction is accepted when input_valid_i && input_ready_o.
- Non-memory instruction accepted in IDLE:
  - Next cycle: reg_write_o = result_write_i && (result_addr_i != 0); reg_addr_o/reg_data_o = result_addr_i/result_i.
  - Stays in IDLE; back-to-back throughput is 1 per cycle.
- Alignment checks for memory instructions (offset = addr[1:0]):
  - Half with offset[0]=1 is misaligned.
  - Word with offset != 0 is misaligned.
- Misaligned load/store accepted: next cycle misaligned_o=1, no bus request, no write-back; stays in IDLE.
- Aligned load/store accepted:
  - Latches address, size, unsigned flag, register address and write data.
  - Next cycle: state=REQ, mem_req_o=1.
  - mem_we_o = ls_write_i.
  - mem_sel_o: byte 4'b0001<<offset; half 4'b0011<<offset; word 4'b1111.
  - mem_wdata_o = ls_wdata_i << (8*offset).
- REQ state:
  - All bus outputs are held stable while mem_req_o=1.
  - The counter increments each cycle without an ack. mem_ack_i is valid in the first REQ cycle.
  - On mem_ack_i: next cycle mem_req_o=0, state=IDLE.
    - Load: reg_write_o = (rd != 0) with reg_data_o = extended (mem_rdata_i >> 8*offset).
    - Byte: bit 7 sign, unless ls_unsigned_i.
    - Half: bit 15 sign, unless ls_unsigned_i.
    - Store: no write-back.
  - Timeout: when the counter reaches TIMEOUT_CYCLES-1 with no ack, next cycle mem_req_o=0, bus_error_o=1, no write-back, state=IDLE.
  - Ack arriving in the timeout cycle wins (normal completion).
- reg_write_o, misaligned_o and bus_error_o are single-cycle pulses. reg_addr_o/reg_data_o hold their last value.
- mem_ack_i outside REQ is ignored.
- input_valid_i is ignored while not in IDLE.
- Reset asserted mid-transaction: mem_req_o=0 on the next edge, no write-back, state=IDLE.

Test Plan:
- ALU pass-through: valid, rd=5, result_i=0x1234, ls_enable_i=0 -> next cycle reg_write_o=1, reg_addr_o=5, reg_data_o=0x1234; rd=0 -> reg_write_o=0.
- Signed byte load:
  - Stimulus: addr 0x1003, size=0, unsigned=0; ack with rdata 0x80FFFFFF 2 cycles after req.
  - Response: mem_addr_o=0x1000, mem_sel_o=0001<<3=1000; reg_data_o=0xFFFFFF80 one cycle after ack; input_ready_o=0 throughout.
- Half store:
  - Stimulus: addr 0x2002, size=1, wdata 0xABCD.
  - Response: mem_we_o=1, mem_sel_o=1100, mem_wdata_o=0xABCD0000; ack -> no reg_write_o, input_ready_o=1 next cycle.
- Misaligned: word load at 0x3001 -> misaligned_o pulse, mem_req_o stays 0, no write-back.
- Timeout: TIMEOUT_CYCLES=4, load with no ack -> mem_req_o high 4 cycles, then bus_error_o pulse, state IDLE; repeat with ack in 4th cycle -> normal write-back, no error.
- Reset mid-REQ: rst_i during REQ -> next cycle mem_req_o=0, input_ready_o=1 after release, subsequent ack ignored.
